int_ctrl: RTL and testbench
===========================

# int_ctrl

Parametrised vectored interrupt controller that generalises the control unit's single `hwint`/`int_mask` interrupt path to `NUM_IRQ` prioritised sources. It sits between peripheral interrupt lines and the control unit. It latches requests, arbitrates by fixed priority against the in-service set, and presents one `hwint` request to the CU. On the CU's acknowledge it returns a per-channel vector for loading into PC. End-of-interrupt retires the active handler, and the in-service tracking allows nested, priority-preempting handlers.

## Interface
- `NUM_IRQ`, 8: number of interrupt sources, 1..32; index 0 is highest priority.
- `EDGE_TRIG`, `32'hffffffff`: bit i = 1 makes channel i rising-edge triggered; bit i = 0 makes it level triggered.
- `VECTOR_BASE`, `32'h00000010`: vector address of channel 0.
- `VECTOR_STRIDE`, `32'h00000001`: vector spacing between channels.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq`  in  NUM_IRQ  interrupt lines, already synchronous to `clk`.
- `int_mask`  in  1  global enable from CPU status; 0 forces `hwint` low.
- `enable_in`  in  NUM_IRQ  new channel-enable value.
- `ld_enable`  in  1  loads `enable_in` into the enable register.
- `int_ack`  in  1  one-cycle pulse from the CU (HWINT1 state) taking the current winner.
- `eoi`  in  1  one-cycle end-of-interrupt pulse.
- `hwint`  out  1  request to the CU.
- `vector`  out  32  handler address latched at acknowledge.
- `int_id`  out  ID_W = max(1, $clog2(NUM_IRQ))  channel latched at acknowledge.
- `pending`  out  NUM_IRQ  pending register.
- `in_service`  out  NUM_IRQ  in-service register.

## Operation
- **Edge channels:** `irq_q` holds the previous sample. Rising edge sets `pending[i] |= irq[i] & ~irq_q[i]`. Acknowledge of channel i clears it.
- **Level channels:** `pending[i]` is the registered `irq[i]`. Acknowledge does not clear it; the source must drop the line.
- **Clear/set collision:** the clear takes effect first, then the set. An edge arriving in the same cycle as its own acknowledge leaves `pending[i] = 1`.
- **Eligibility:** `eligible = pending & enable`.
- **Winner:** the lowest eligible index.
- **Request:** `hwint = int_mask & winner exists & (in_service == 0 | winner index < lowest set in_service index)`. `hwint` is combinational from registers and `int_mask`.
- **Acknowledge with a winner:**
  - `int_id <= winner`.
  - `vector <= VECTOR_BASE + winner*VECTOR_STRIDE`, modulo 2^32.
  - `in_service[winner] <= 1`.
  - Clear pending for edge channels.
- **Spurious acknowledge** (`int_ack` while no winner qualifies):
  - `int_id <= 0`.
  - `vector <= VECTOR_BASE + NUM_IRQ*VECTOR_STRIDE`.
  - No register changes.
- **End of interrupt:** `eoi` clears the lowest-index set `in_service` bit. With `in_service == 0` it has no effect.
- **`eoi` and `int_ack` in the same cycle:** the EOI clear is applied to the old `in_service`. Winner qualification is evaluated on the old value. The acknowledge then sets its bit.
- **Enable write:** `ld_enable` takes effect next cycle. A disabled channel keeps its pending bit and requests again when re-enabled.
- **Unused bits:** bits of `EDGE_TRIG` at or above `NUM_IRQ` are ignored.

## Timing
- **Reset values:**
  - `pending`, `in_service`, `enable`, `irq_q`, `int_id`, `vector`: 0.
  - `hwint`: 0.
- **Request latency:** an `irq` rise sampled at edge E gives `pending` = 1 and `hwint` = 1 (if qualified) in the cycle after E.
- **`int_mask` path:** `int_mask` affects `hwint` in the same cycle (combinational).
- **Acknowledge:** `int_ack` sampled at edge E gives `vector`, `int_id` and `in_service` valid after E. The CU reads `vector` in HWINT2, one cycle later. `hwint` drops after E unless another winner still qualifies.
- **Holding:** `vector` and `int_id` hold until the next `int_ack` or `rst`.
- **Reset priority:** `rst` has priority over all inputs. Reset mid-handler clears `in_service` and loses pending edges.

## Test plan
- **Single edge request:** enable = `8'h08`, `int_mask` = 1, pulse `irq[3]`. Expect `hwint` = 1 next cycle. `int_ack` gives `vector` = `32'h13`, `int_id` = 3, `in_service` = `8'h08`, `pending[3]` = 0, `hwint` = 0. `eoi` gives `in_service` = 0.
- **Priority and nesting:** `irq[5]` and `irq[2]` rise together. Ack gives channel 2 (`vector` `32'h12`). Raise `irq[6]`: `hwint` stays 0 because 6 is not above 2. Raise `irq[0]`: `hwint` = 1. Ack gives channel 0 and `in_service` = `8'h05`. `eoi` gives `8'h04`. Channel 5 stays pending, blocked until a second `eoi`.
- **Level channel:** `EDGE_TRIG` bit 1 = 0, hold `irq[1]` high. Ack gives channel 1 and `pending[1]` stays 1. After `eoi`, `hwint` re-asserts. Drop `irq[1]`: `pending[1]` = 0 next cycle.
- **Masking and enable:** pending channel 4 with `int_mask` = 0 gives `hwint` = 0. Clearing enable bit 4 keeps `pending[4]` = 1 and `hwint` = 0. Re-enable with `int_mask` = 1 gives `hwint` = 1 the cycle after `ld_enable`.
- **Spurious and collisions:**
  - `int_ack` with nothing pending gives `vector` = `32'h18` and no state change.
  - Edge on channel 3 in the same cycle as its ack leaves `pending[3]` = 1.
  - `eoi` + `int_ack` in the same cycle apply as specified under Operation.
- **Reset mid-handler:** `in_service` = `8'h05`, `pending` = `8'h20`, assert `rst` for one cycle. All outputs read 0 the next cycle.

Source files
------------

// File: rtl/int_ctrl.sv
// Vectored, fixed-priority interrupt controller in front of the CU's single hwint input.
// Latches edge/level requests, arbitrates against the in-service set, and returns a per-channel vector on acknowledge.
module int_ctrl #(
    parameter int          NUM_IRQ       = 8,
    parameter logic [31:0] EDGE_TRIG     = 32'hffffffff,
    parameter logic [31:0] VECTOR_BASE   = 32'h00000010,
    parameter logic [31:0] VECTOR_STRIDE = 32'h00000001,
    localparam int         ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               int_mask,
    input  logic [NUM_IRQ-1:0] enable_in,
    input  logic               ld_enable,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               hwint,
    output logic [31:0]        vector,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);

    localparam logic [31:0] SPUR_VECTOR = VECTOR_BASE + 32'(NUM_IRQ) * VECTOR_STRIDE;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [ID_W-1:0]    r_int_id;
    logic [31:0]        r_vector;

    logic [NUM_IRQ-1:0] w_eligible;
    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_idx;
    logic               w_isr_any;
    logic [ID_W-1:0]    w_isr_idx;
    logic               w_hwint;
    logic               w_ack_ok;
    logic [NUM_IRQ-1:0] w_ack_set;
    logic [NUM_IRQ-1:0] w_eoi_clr;
    logic [NUM_IRQ-1:0] w_pend_next;

    assign w_eligible = r_pending & r_enable;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_valid = 1'b1;
                w_win_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_isr_any = 1'b0;
        w_isr_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (r_in_service[i]) begin
                w_isr_any = 1'b1;
                w_isr_idx = ID_W'(i);
            end
        end
    end

    // A winner only preempts when strictly higher priority than every active handler.
    assign w_hwint   = int_mask & w_win_valid & (~w_isr_any | (w_win_idx < w_isr_idx));
    assign w_ack_ok  = int_ack & w_hwint;
    assign w_ack_set = w_ack_ok ? (NUM_IRQ'(1) << w_win_idx) : '0;
    assign w_eoi_clr = (eoi & w_isr_any) ? (NUM_IRQ'(1) << w_isr_idx) : '0;

    // Edge channels: acknowledge clears first, a fresh edge in the same cycle re-sets.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
        if (EDGE_TRIG[gi]) begin : g_edge
            assign w_pend_next[gi] = (r_pending[gi] & ~w_ack_set[gi]) | (irq[gi] & ~r_irq_q[gi]);
        end else begin : g_level
            assign w_pend_next[gi] = irq[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_in_service <= '0;
            r_enable     <= '0;
            r_irq_q      <= '0;
            r_int_id     <= '0;
            r_vector     <= '0;
        end else begin
            r_irq_q      <= irq;
            r_pending    <= w_pend_next;
            r_in_service <= (r_in_service & ~w_eoi_clr) | w_ack_set;
            if (ld_enable) begin
                r_enable <= enable_in;
            end
            if (int_ack) begin
                if (w_ack_ok) begin
                    r_int_id <= w_win_idx;
                    r_vector <= VECTOR_BASE + 32'(w_win_idx) * VECTOR_STRIDE;
                end else begin
                    r_int_id <= '0;
                    r_vector <= SPUR_VECTOR;
                end
            end
        end
    end

    assign hwint      = w_hwint;
    assign vector     = r_vector;
    assign int_id     = r_int_id;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a vector table for the edge/priority/nesting flow,
// then hand-written sequences for level, masking, spurious, collision and reset cases.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        int_mask;
    logic [7:0]  enable_in;
    logic        ld_enable;
    logic        int_ack;
    logic        eoi;
    logic        hwint;
    logic [31:0] vector;
    logic [2:0]  int_id;
    logic [7:0]  pending;
    logic [7:0]  in_service;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Channel 1 is level triggered; every other channel is edge triggered.
    int_ctrl #(
        .NUM_IRQ      (8),
        .EDGE_TRIG    (32'hfffffffd),
        .VECTOR_BASE  (32'h00000010),
        .VECTOR_STRIDE(32'h00000001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .int_mask  (int_mask),
        .enable_in (enable_in),
        .ld_enable (ld_enable),
        .int_ack   (int_ack),
        .eoi       (eoi),
        .hwint     (hwint),
        .vector    (vector),
        .int_id    (int_id),
        .pending   (pending),
        .in_service(in_service)
    );

    typedef struct {
        logic [7:0]  irq;
        logic        msk;
        logic [7:0]  en;
        logic        ld;
        logic        ack;
        logic        eoi;
        logic        hw;
        logic [7:0]  pend;
        logic [7:0]  isr;
        logic [31:0] vec;
        logic [2:0]  id;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] i_irq, input logic msk, input logic [7:0] en,
                         input logic ld, input logic ack, input logic e);
        irq       = i_irq;
        int_mask  = msk;
        enable_in = en;
        ld_enable = ld;
        int_ack   = ack;
        eoi       = e;
        tick();
    endtask

    task automatic chk_all(input string tag, input logic hw, input logic [7:0] pend,
                           input logic [7:0] isr, input logic [31:0] vec, input logic [2:0] id);
        chk({tag, ".hwint"}, 32'(hwint), 32'(hw));
        chk({tag, ".pending"}, 32'(pending), 32'(pend));
        chk({tag, ".in_service"}, 32'(in_service), 32'(isr));
        chk({tag, ".vector"}, vector, vec);
        chk({tag, ".int_id"}, 32'(int_id), 32'(id));
        $display("[%0t] %s hwint=%0b pend=%h isr=%h vec=%h id=%0d",
                 $time, tag, hwint, pending, in_service, vector, int_id);
    endtask

    initial begin
        // irq  msk en  ld ack eoi | hw pend isr vec id
        tbl.push_back('{8'h00, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h00, 3'd0});
        tbl.push_back('{8'h08, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h00, 32'h00, 3'd0});
        tbl.push_back('{8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h00, 32'h00, 3'd0});
        tbl.push_back('{8'h00, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h08, 32'h13, 3'd3});
        tbl.push_back('{8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 32'h13, 3'd3});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h13, 3'd3});
        tbl.push_back('{8'h24, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0, 1'b1, 8'h24, 8'h00, 32'h13, 3'd3});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h04, 32'h12, 3'd2});
        tbl.push_back('{8'h40, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0, 8'h60, 8'h04, 32'h12, 3'd2});
        tbl.push_back('{8'h41, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0, 1'b1, 8'h61, 8'h04, 32'h12, 3'd2});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0, 1'b0, 8'h60, 8'h05, 32'h10, 3'd0});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60, 8'h04, 32'h10, 3'd0});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1, 1'b1, 8'h60, 8'h00, 32'h10, 3'd0});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h20, 32'h15, 3'd5});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 32'h15, 3'd5});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 32'h16, 3'd6});
        tbl.push_back('{8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 32'h16, 3'd6});

        // Reset
        rst = 1'b1; irq = '0; int_mask = 1'b1; enable_in = '0; ld_enable = 1'b0;
        int_ack = 1'b0; eoi = 1'b0;
        tick();
        tick();
        chk_all("reset", 1'b0, 8'h00, 8'h00, 32'h0, 3'd0);
        rst = 1'b0;

        // Edge request, priority and nested preemption
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].irq, tbl[k].msk, tbl[k].en, tbl[k].ld, tbl[k].ack, tbl[k].eoi);
            chk_all($sformatf("tbl%0d", k), tbl[k].hw, tbl[k].pend, tbl[k].isr, tbl[k].vec, tbl[k].id);
        end

        // Level channel 1: ack leaves pending set, eoi re-requests, drop clears
        drive(8'h02, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        chk_all("lvl_rise", 1'b1, 8'h02, 8'h00, 32'h16, 3'd6);
        drive(8'h02, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        chk_all("lvl_ack", 1'b0, 8'h02, 8'h02, 32'h11, 3'd1);
        drive(8'h02, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1);
        chk_all("lvl_eoi", 1'b1, 8'h02, 8'h00, 32'h11, 3'd1);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        chk_all("lvl_drop", 1'b0, 8'h00, 8'h00, 32'h11, 3'd1);

        // Masking and enable
        drive(8'h10, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        chk_all("msk_pend", 1'b1, 8'h10, 8'h00, 32'h11, 3'd1);
        irq = 8'h00; int_mask = 1'b0; #1;
        chk("msk_comb.hwint", 32'(hwint), 32'd0);
        drive(8'h00, 1'b0, 8'hef, 1'b1, 1'b0, 1'b0);
        chk_all("en_clear", 1'b0, 8'h10, 8'h00, 32'h11, 3'd1);
        int_mask = 1'b1; ld_enable = 1'b0; #1;
        chk("en_off_unmasked.hwint", 32'(hwint), 32'd0);
        enable_in = 8'hff; ld_enable = 1'b1; #1;
        chk("en_before_edge.hwint", 32'(hwint), 32'd0);
        tick();
        ld_enable = 1'b0;
        chk_all("en_reload", 1'b1, 8'h10, 8'h00, 32'h11, 3'd1);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        chk_all("en_ack", 1'b0, 8'h00, 8'h10, 32'h14, 3'd4);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1);
        chk_all("en_eoi", 1'b0, 8'h00, 8'h00, 32'h14, 3'd4);

        // Spurious acknowledge
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        chk_all("spur", 1'b0, 8'h00, 8'h00, 32'h18, 3'd0);

        // Edge arriving with its own acknowledge stays pending
        drive(8'h08, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        chk_all("coll_pend", 1'b1, 8'h08, 8'h00, 32'h18, 3'd0);
        drive(8'h08, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        chk_all("coll_ack", 1'b0, 8'h08, 8'h08, 32'h13, 3'd3);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1);
        chk_all("coll_eoi", 1'b1, 8'h08, 8'h00, 32'h13, 3'd3);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1);
        chk_all("coll_done", 1'b0, 8'h00, 8'h00, 32'h13, 3'd3);

        // eoi + ack together: qualification on old in_service, eoi clear then ack set
        drive(8'h04, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        chk_all("ea_isr2", 1'b0, 8'h00, 8'h04, 32'h12, 3'd2);
        drive(8'h01, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b1);
        chk_all("ea_preempt", 1'b0, 8'h00, 8'h01, 32'h10, 3'd0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1);
        drive(8'h04, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        drive(8'h20, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        chk_all("ea_blocked", 1'b0, 8'h20, 8'h04, 32'h12, 3'd2);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b1);
        chk_all("ea_spur", 1'b1, 8'h20, 8'h00, 32'h18, 3'd0);

        // Reset mid-handler with in_service = 05, pending = 20
        drive(8'h04, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        drive(8'h01, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
        chk_all("pre_rst", 1'b0, 8'h20, 8'h05, 32'h10, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("mid_rst", 1'b0, 8'h00, 8'h00, 32'h0, 3'd0);
        drive(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_all("post_rst", 1'b0, 8'h00, 8'h00, 32'h0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
